// File: rtl/aes256_key_expansion_inverse.sv
// Reverse AES-256 key schedule: loads {rk13, rk14} and streams round keys
// rk14 down to rk0, one per accepted cycle, rebuilding each earlier round
// key from the two most recent ones so that no key table is needed.
module aes256_key_expansion_inverse (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         rk_last,
    output logic         rk_valid,
    input  logic         rk_ready
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES S-box: multiplicative inverse (x^254, zero maps to zero) then affine map
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] pw;
        logic [7:0] inv;
        pw  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            pw  = gf_mul(pw, pw);
            inv = gf_mul(inv, pw);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Round constant for the even-index steps (idx/2 = 1..7)
    function automatic logic [7:0] rcon(input logic [2:0] j);
        case (j)
            3'd1:    return 8'h01;
            3'd2:    return 8'h02;
            3'd3:    return 8'h04;
            3'd4:    return 8'h08;
            3'd5:    return 8'h10;
            3'd6:    return 8'h20;
            3'd7:    return 8'h40;
            default: return 8'h00;
        endcase
    endfunction

    logic [0:0]   state;
    logic [0:0]   state_next;
    logic [255:0] window;     // {rk(idx-1), rk(idx)}
    logic [3:0]   idx;
    logic         ready_q;
    logic         load;
    logic         emit_hs;

    logic [31:0]  a3;
    logic [31:0]  b0;
    logic [31:0]  b1;
    logic [31:0]  b2;
    logic [31:0]  b3;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  t_word;
    logic [127:0] derived;

    assign load     = key_valid && key_ready;
    assign emit_hs  = rk_valid && rk_ready;

    assign key_ready = ready_q;
    assign rk_valid  = (state == EMIT);
    assign rk_data   = window[127:0];
    assign rk_idx    = idx;
    assign rk_last   = rk_valid && (idx == 4'd0);

    assign a3 = window[159:128];
    assign b0 = window[127:96];
    assign b1 = window[95:64];
    assign b2 = window[63:32];
    assign b3 = window[31:0];

    // Odd steps skip RotWord and the round constant
    assign rot_word = idx[0] ? a3 : {a3[23:0], a3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign sub_word[8*g +: 8] = aes_sbox(rot_word[8*g +: 8]);
    end

    assign t_word  = idx[0] ? sub_word : (sub_word ^ {rcon(idx[3:1]), 24'h000000});
    assign derived = (idx == 4'd1) ? 128'h0 : {b0 ^ t_word, b1 ^ b0, b2 ^ b1, b3 ^ b2};

    // Next-state selection for the load/emit controller
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = EMIT;
            EMIT:    if (emit_hs && (idx == 4'd0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, key window and index registers; key_ready is registered so it stays low in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            window  <= '0;
            idx     <= 4'd0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next == IDLE);
            if (load) begin
                window <= key_in;
                idx    <= 4'd14;
            end else if (emit_hs && (idx != 4'd0)) begin
                window <= {derived, window[255:128]};
                idx    <= idx - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes256_key_expansion_inverse.sv
// Scoreboard bench for the reverse AES-256 key schedule: the stimulus side
// pushes expected round keys per load, a negedge monitor pops and compares
// every accepted output and checks stability while stalled.
module tb_aes256_key_expansion_inverse;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         rk_valid;
    logic         rk_ready;

    aes256_key_expansion_inverse dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_data   (rk_data),
        .rk_idx    (rk_idx),
        .rk_last   (rk_last),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] data;
    } exp_t;

    exp_t         q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           last_rk0_edge = -1;
    logic [127:0] model_rk [0:14];

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [2047:0] t;
        int k;
        t = SBOX;
        k = int'(x);
        return t[2047 - 8*k -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    // Forward AES-256 key expansion into model_rk[0..14]
    task automatic expand(input logic [255:0] key);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0};
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int j = 0; j < 15; j++) model_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present {rk13, rk14} from model_rk and wait for the load handshake
    task automatic issue_load(output int edge_n);
        key_in    = {model_rk[13], model_rk[14]};
        key_valid = 1'b1;
        edge_n    = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (key_ready) begin
                edge_n = cyc + 1;
                break;
            end
        end
        if (edge_n < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL load_timeout: got key_ready=0 expected handshake within 100 cycles");
            key_valid = 1'b0;
        end else begin
            for (int j = 14; j >= 0; j--) q.push_back({4'(j), model_rk[j]});
            @(posedge clk);
            #1;
            key_valid = 1'b0;
        end
    endtask

    task automatic drain(input bit rnd);
        for (int n = 0; n < 400; n++) begin
            if (q.size() == 0) begin
                rk_ready = 1'b1;
                return;
            end
            if (rnd) rk_ready = 1'($urandom_range(0, 1));
            tick();
        end
        n_checks++;
        n_fail++;
        $display("FAIL drain_timeout: got %0d pending outputs expected 0", q.size());
        rk_ready = 1'b1;
    endtask

    // Monitor: compares every accepted key and checks hold behaviour while stalled
    logic         stalled = 1'b0;
    logic [127:0] held_data;
    logic [3:0]   held_idx;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 128'(rk_valid), 128'd1);
                check("stall_data", rk_data, held_data);
                check("stall_idx", 128'(rk_idx), 128'(held_idx));
            end
            if (rk_valid) begin
                check("rk_last", 128'(rk_last), 128'(rk_idx == 4'd0));
                if (rk_ready) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got idx %0d expected none", rk_idx);
                    end else begin
                        e = q.pop_front();
                        check("rk_idx", 128'(rk_idx), 128'(e.idx));
                        check("rk_data", rk_data, e.data);
                    end
                    if (rk_idx == 4'd0) last_rk0_edge = cyc + 1;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held_data = rk_data;
                    held_idx  = rk_idx;
                end
            end else begin
                check("rk_last_idle", 128'(rk_last), 128'd0);
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e1;
        int e2;
        int found;
        rst_n     = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        rk_ready  = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("reset_key_ready", 128'(key_ready), 128'd0);
        check("reset_rk_valid", 128'(rk_valid), 128'd0);
        check("reset_rk_data", rk_data, 128'h0);
        check("reset_rk_idx", 128'(rk_idx), 128'd0);
        check("reset_rk_last", 128'(rk_last), 128'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("key_ready_after_reset", 128'(key_ready), 128'd1);
        rk_ready = 1'b1;
        // Rising edge of rk_ready in IDLE must not start anything
        check("idle_rk_valid", 128'(rk_valid), 128'd0);

        // FIPS-197 C.3 key with hand vectors for the end points
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        model_rk[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
        model_rk[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
        model_rk[1]  = 128'h101112131415161718191a1b1c1d1e1f;
        model_rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        issue_load(e1);
        drain(1'b0);
        check("fips_consecutive", 128'(last_rk0_edge - e1), 128'd15);
        tick();
        check("key_ready_after_rk0", 128'(key_ready), 128'd1);

        // Random keys with random backpressure
        for (int k = 0; k < 200; k++) begin
            expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            issue_load(e1);
            drain(1'b1);
        end

        // key_valid during EMIT is ignored; next load lands the cycle after rk0
        rk_ready = 1'b1;
        expand({8{32'hdeadbeef}});
        issue_load(e1);
        repeat (2) tick();
        key_in    = {8{32'h5a5a5a5a}};
        key_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("key_ready_in_emit", 128'(key_ready), 128'd0);
        end
        expand(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        issue_load(e2);
        check("reload_gap", 128'(e2 - last_rk0_edge), 128'd1);
        drain(1'b0);

        // Asynchronous reset while stalled at idx 7
        expand({8{32'h0badf00d}});
        issue_load(e1);
        found = 0;
        for (int n = 0; n < 40 && found == 0; n++) begin
            if (rk_valid && rk_idx == 4'd7) found = 1;
            else tick();
        end
        check("reach_idx7", 128'(found), 128'd1);
        rk_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_rk_valid", 128'(rk_valid), 128'd0);
        check("async_rst_key_ready", 128'(key_ready), 128'd0);
        check("async_rst_rk_data", rk_data, 128'h0);
        q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("key_ready_after_rst", 128'(key_ready), 128'd1);
        check("no_emit_after_rst", 128'(rk_valid), 128'd0);
        rk_ready = 1'b1;
        expand(256'hfedcba9876543210f0e1d2c3b4a5968778695a4b3c2d1e0f0123456789abcdef);
        issue_load(e1);
        drain(1'b0);

        // Long stalls on the RotWord path (idx 2) and the SubWord-only path (idx 1)
        expand(256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7bc5b2c1d9e18a7d60);
        issue_load(e1);
        found = 0;
        for (int n = 0; n < 40 && found == 0; n++) begin
            if (rk_valid && rk_idx == 4'd2) found = 1;
            else tick();
        end
        check("reach_idx2", 128'(found), 128'd1);
        rk_ready = 1'b0;
        repeat (10) tick();
        rk_ready = 1'b1;
        tick();
        check("idx1_after_stall", 128'(rk_idx), 128'd1);
        rk_ready = 1'b0;
        repeat (10) tick();
        rk_ready = 1'b1;
        drain(1'b0);

        // Back-to-back loads
        expand(256'h00112233445566778899aabbccddeeff0123456789abcdeffedcba9876543210);
        issue_load(e1);
        expand(256'hffeeddccbbaa99887766554433221100102030405060708090a0b0c0d0e0f000);
        issue_load(e2);
        drain(1'b0);
        check("b2b_load_gap", 128'(e2 - e1), 128'd16);
        check("b2b_total", 128'(last_rk0_edge - e1), 128'd31);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
